reaction_timer: RTL and testbench

Millisecond reaction timer that sits directly downstream of the reaction-test control FSM. It consumes that FSM's `start_timer`/`stop_timer` pulses, counts elapsed milliseconds from a prescaled system clock, and produces the saturating 14-bit `elapsed_time` (0–9999) that the FSM and the display path read. It also keeps a best-time (fastest valid reaction) register, which can be compiled out.

---
 rtl/reaction_timer.sv | 151 +++++++++++++++
 tb/tb_reaction_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Millisecond reaction timer: counts prescaled 1 ms ticks between start/stop pulses, saturating at MAX_COUNT.
// Latency: every output is registered and reflects the inputs sampled on the previous rising clk edge.
// Backpressure: none; start/stop/clear are single-cycle pulses that are acted on in the cycle they arrive.
//
// Ports:
//   clk, reset_n           - system clock (rising edge), asynchronous active-low reset
//   start_timer            - clear the count and begin counting (wins over stop_timer and clear)
//   stop_timer             - freeze the count while running and pulse valid
//   clear                  - synchronous return to idle with a zero count (best time kept)
//   elapsed_time[13:0]     - running or frozen millisecond count, saturates at MAX_COUNT
//   running                - high while counting
//   overflow               - sticky: a tick arrived while the count was already at MAX_COUNT
//   valid                  - one-cycle pulse when a final result is captured
//   best_time[13:0]        - fastest non-overflowed result since reset (BEST_TIME_EN only)
//   new_best               - one-cycle pulse, coincident with valid, when best_time improves (BEST_TIME_EN only)
//
// Build option: define BEST_TIME_EN to include the best-time register and its two ports.

module reaction_timer #(
    parameter int TICK_DIV  = 10000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_timer,
    input  logic        stop_timer,
    input  logic        clear,
    output logic [13:0] elapsed_time,
    output logic        running,
    output logic        overflow,
    output logic        valid
`ifdef BEST_TIME_EN
    ,
    output logic [13:0] best_time,
    output logic        new_best
`endif
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]     MAX_VAL   = 14'(MAX_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic [13:0]   count_q,   count_d;
    logic          ovf_q,     ovf_d;
    logic          valid_q,   valid_d;
    logic          running_q, running_d;
    logic          tick;

`ifdef BEST_TIME_EN
    logic [13:0]   best_q,     best_d;
    logic          best_vld_q, best_vld_d;
    logic          new_best_q, new_best_d;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        tick    = 1'b0;
`ifdef BEST_TIME_EN
        best_d     = best_q;
        best_vld_d = best_vld_q;
        new_best_d = 1'b0;
`endif

        if (start_timer) begin
            // Start restarts from any state, even a live run, and suppresses a same-cycle stop.
            state_d = S_RUN;
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            tick    = (presc_q == TICK_LAST);
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                if (count_q < MAX_VAL) begin
                    count_d = count_q + 14'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            // The tick above is folded into the captured value before freezing.
            if (stop_timer) begin
                state_d = S_HOLD;
                valid_d = 1'b1;
`ifdef BEST_TIME_EN
                if (!ovf_d && (!best_vld_q || (count_d < best_q))) begin
                    best_d     = count_d;
                    best_vld_d = 1'b1;
                    new_best_d = 1'b1;
                end
`endif
            end
        end

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
`ifdef BEST_TIME_EN
            best_q     <= '0;
            best_vld_q <= 1'b0;
            new_best_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            running_q <= running_d;
`ifdef BEST_TIME_EN
            best_q     <= best_d;
            best_vld_q <= best_vld_d;
            new_best_q <= new_best_d;
`endif
        end
    end

    assign elapsed_time = count_q;
    assign running      = running_q;
    assign overflow     = ovf_q;
    assign valid        = valid_q;
`ifdef BEST_TIME_EN
    assign best_time    = best_q;
    assign new_best     = new_best_q;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Testbench for reaction_timer: directed scenarios followed by random start/stop/clear traffic.
// Expected outputs come from an elapsed-edges model: count = min((edges since start)/TICK_DIV, MAX_COUNT).
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.

module tb_reaction_timer;

    localparam int TD   = 4;
    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_timer = 1'b0;
    logic        stop_timer = 1'b0;
    logic        clear = 1'b0;
    logic [13:0] elapsed_time;
    logic        running;
    logic        overflow;
    logic        valid;
`ifdef BEST_TIME_EN
    logic [13:0] best_time;
    logic        new_best;
`endif

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Reference model: 0 = idle, 1 = counting, 2 = holding a result.
    int m_state;
    int m_start;
    int m_val;
    bit m_ovf;
    bit m_valid;
`ifdef BEST_TIME_EN
    int m_best;
    bit m_bv;
    bit m_nb;
`endif

    always #5 clk = ~clk;

    reaction_timer #(
        .TICK_DIV  (TD),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_timer  (start_timer),
        .stop_timer   (stop_timer),
        .clear        (clear),
        .elapsed_time (elapsed_time),
        .running      (running),
        .overflow     (overflow),
        .valid        (valid)
`ifdef BEST_TIME_EN
        ,
        .best_time    (best_time),
        .new_best     (new_best)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("elapsed_time", 32'(elapsed_time), 32'(m_val));
        chk("running",      32'(running),      32'(m_state == 1));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("valid",        32'(valid),        32'(m_valid));
`ifdef BEST_TIME_EN
        chk("best_time",    32'(best_time),    32'(m_best));
        chk("new_best",     32'(new_best),     32'(m_nb));
`endif
    endtask

    task automatic model_reset();
        m_state = 0;
        m_start = 0;
        m_val   = 0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
`ifdef BEST_TIME_EN
        m_best  = 0;
        m_bv    = 1'b0;
        m_nb    = 1'b0;
`endif
    endtask

    // One clock cycle with the given pulses, then model update and full output check.
    task automatic step(input bit st, input bit sp, input bit cl);
        int k;
        start_timer = st;
        stop_timer  = sp;
        clear       = cl;
        @(posedge clk);
        edge_n++;
        m_valid = 1'b0;
`ifdef BEST_TIME_EN
        m_nb = 1'b0;
`endif
        if (st) begin
            m_state = 1;
            m_start = edge_n;
            m_val   = 0;
            m_ovf   = 1'b0;
        end else if (cl) begin
            m_state = 0;
            m_val   = 0;
            m_ovf   = 1'b0;
        end else if (m_state == 1) begin
            k     = (edge_n - m_start) / TD;
            m_val = (k > MAXC) ? MAXC : k;
            m_ovf = (k > MAXC);
            if (sp) begin
                m_state = 2;
                m_valid = 1'b1;
`ifdef BEST_TIME_EN
                if (!m_ovf && (!m_bv || m_val < m_best)) begin
                    m_best = m_val;
                    m_bv   = 1'b1;
                    m_nb   = 1'b1;
                end
`endif
            end
        end
        #1;
        start_timer = 1'b0;
        stop_timer  = 1'b0;
        clear       = 1'b0;
        check_outputs();
    endtask

    task automatic run_for(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-on reset.
        model_reset();
        #1;
        check_outputs();
        #2;
        reset_n = 1'b1;

        // Start sampled on edge 10, stop 123 ticks later.
        run_for(9);
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 123 - 1);
        step(1'b0, 1'b1, 1'b0);
        chk("result_123", 32'(elapsed_time), 32'd123);
        chk("valid_123", 32'(valid), 32'd1);

        // Stop in HOLD, clear, stop in IDLE.
        step(1'b0, 1'b1, 1'b0);
        chk("hold_stop_value", 32'(elapsed_time), 32'd123);
        step(1'b0, 1'b0, 1'b1);
        chk("clear_value", 32'(elapsed_time), 32'd0);
        step(1'b0, 1'b1, 1'b0);

        // Stop exactly on the 50th tick.
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 50 - 1);
        step(1'b0, 1'b1, 1'b0);
        chk("result_50", 32'(elapsed_time), 32'd50);

        // Restart from HOLD, then start+stop together.
        step(1'b1, 1'b0, 1'b0);
        run_for(10);
        step(1'b1, 1'b1, 1'b0);
        chk("start_stop_running", 32'(running), 32'd1);
        run_for(5);

        // Asynchronous reset mid-run at count 37, then a fresh start.
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 37);
        chk("count_37", 32'(elapsed_time), 32'd37);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #1 reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 2);
        chk("after_reset_count", 32'(elapsed_time), 32'd2);

        // Results 300, 250, 250.
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 300 - 1);
        step(1'b0, 1'b1, 1'b0);
        repeat (2) begin
            step(1'b1, 1'b0, 1'b0);
            run_for(TD * 250 - 1);
            step(1'b0, 1'b1, 1'b0);
        end
`ifdef BEST_TIME_EN
        chk("best_250", 32'(best_time), 32'd250);
`endif

        // Saturation and overflow, then stop.
        step(1'b1, 1'b0, 1'b0);
        run_for(TD * 10005);
        chk("sat_value", 32'(elapsed_time), 32'd9999);
        chk("sat_overflow", 32'(overflow), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_result", 32'(elapsed_time), 32'd9999);
`ifdef BEST_TIME_EN
        chk("best_after_ovf", 32'(best_time), 32'd250);
`endif

        // Random pulse traffic.
        for (int i = 0; i < 3000; i++) begin
            bit st;
            bit sp;
            bit cl;
            st = ($urandom_range(0, 49) == 0);
            sp = ($urandom_range(0, 29) == 0);
            cl = ($urandom_range(0, 99) == 0);
            step(st, sp, cl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
